ram_stream_reader: RTL and testbench

//   Read-side sequencer for the simple dual-port RAM (1-cycle registered read, old-data-on-collision).
//   On start: reads LENGTH consecutive words from BASE, wrapping modulo 2**ADDR_WIDTH.

---
 rtl/ram_stream_reader.sv | 227 ++++++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side sequencer for a simple dual-port RAM with a 1-cycle registered
//   read. A burst of `length` words starting at `base_addr` (wrapping at the
//   top of the address space) is streamed out on a valid/ready interface.
//   A 2-entry output buffer absorbs the RAM read latency so that one word per
//   cycle is sustained while still honouring full backpressure.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int BUF_DEPTH = 2;
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_reg;
  state_t                state_next;

  logic [ADDR_WIDTH-1:0] rd_addr_reg;
  logic [ADDR_WIDTH:0]   issue_cnt_reg;   // reads still to be issued
  logic [ADDR_WIDTH:0]   out_cnt_reg;     // words still to be transferred
  logic                  inflight_reg;    // a RAM read is returning this cycle
  logic                  done_reg;

  // Output buffer: tiny circular queue held in flops so it can be cleared on reset
  logic [DATA_WIDTH-1:0] buf_reg [BUF_DEPTH];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            occ_reg;

  // Control strobes produced by the FSM output process
  logic                  launch;          // accept a non-empty burst
  logic                  zero_start;      // accept a zero-length burst
  logic                  issue;           // RAM samples rd_addr at this edge
  logic                  final_xfer;      // last word of the burst leaves now
  logic                  busy_int;

  logic                  push;
  logic                  pop;
  logic [2:0]            slots_used;

  // Buffer handshake: a returning read always pushes; a stream transfer pops
  always_comb begin
    push       = inflight_reg;
    pop        = (occ_reg != 2'd0) & m_ready;
    // Space the buffer will need after this edge if another read is issued now.
    // pop implies occ_reg >= 1, so the subtraction never underflows.
    slots_used = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (launch) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // The last read has been issued; only the tail remains to drain
        if (issue && (issue_cnt_reg == CNT_ONE)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (final_xfer) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: burst acceptance, read issue throttle and completion detect
  always_comb begin
    launch     = 1'b0;
    zero_start = 1'b0;
    issue      = 1'b0;
    final_xfer = 1'b0;
    busy_int   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        launch     = start & (length != CNT_ZERO);
        zero_start = start & (length == CNT_ZERO);
      end
      ST_RUN: begin
        busy_int = 1'b1;
        // Only issue if the word will have a guaranteed slot when it returns
        issue    = (slots_used < 3'd2);
      end
      ST_DRAIN: begin
        busy_int   = 1'b1;
        final_xfer = pop & (out_cnt_reg == CNT_ONE);
      end
      default: begin
        busy_int = 1'b0;
      end
    endcase
  end

  // Read address: loaded with the base, then advanced once per issued read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_reg <= '0;
    end else if (launch) begin
      rd_addr_reg <= base_addr;
    end else if (issue) begin
      // Natural overflow of the register provides the modulo-depth wrap
      rd_addr_reg <= rd_addr_reg + 1'b1;
    end
  end

  // Remaining-read counter, decremented per issued read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_reg <= '0;
    end else if (launch) begin
      issue_cnt_reg <= length;
    end else if (issue) begin
      issue_cnt_reg <= issue_cnt_reg - CNT_ONE;
    end
  end

  // Remaining-word counter, decremented per stream transfer; drives m_last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_reg <= '0;
    end else if (launch) begin
      out_cnt_reg <= length;
    end else if (pop) begin
      out_cnt_reg <= out_cnt_reg - CNT_ONE;
    end
  end

  // In-flight flag: a read issued at this edge has its data valid next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= issue;
    end
  end

  // Done pulse: one cycle after the last transfer or a zero-length start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= zero_start | final_xfer;
    end
  end

  // Buffer storage: each entry captures RAM data when it is the write target
  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_buf
      localparam logic SLOT = 1'(gi);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buf_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == SLOT)) begin
          buf_reg[gi] <= rd_data;
        end
      end
    end
  endgenerate

  // Buffer pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Stream outputs come straight from the buffer head, so they hold while stalled
  always_comb begin
    rd_addr = rd_addr_reg;
    m_valid = (occ_reg != 2'd0);
    m_data  = buf_reg[rd_ptr_reg];
    m_last  = m_valid & (out_cnt_reg == CNT_ONE);
    busy    = busy_int;
    done    = done_reg;
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader
//   Directed and randomized bursts against a behavioural RAM plus a
//   queue-based model of the expected word stream.
module tb_ram_stream_reader;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b1;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [DEPTH];

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Behavioural RAM read port: 1-cycle registered read
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One burst: expected words are mem[(base+i) mod DEPTH] in order.
  // stall_pct > 0 randomizes m_ready; abort_after >= 0 resets after that many words.
  task automatic run_burst(input logic [AW-1:0] base, input int len, input int stall_pct,
                           input int abort_after, input bit poke_start);
    logic [DW-1:0] expq[$];
    logic [DW-1:0] held;
    logic [AW-1:0] a;
    bit            done_due;
    bit            finished;
    bit            stalled;
    bit            xfer;
    int            got;
    int            end_idx;
    int            budget;
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      expq.push_back(mem[a]);
    end
    @(negedge clk);
    base_addr = base;
    length    = len[AW:0];
    start     = 1'b1;
    done_due  = (len == 0);
    finished  = 1'b0;
    stalled   = 1'b0;
    held      = '0;
    got       = 0;
    end_idx   = (len == 0) ? 3 : -1;
    budget    = 8 * len + 20;
    for (int idx = 0; idx < budget; idx++) begin
      @(negedge clk);
      start = poke_start && (idx == 3);
      if (poke_start && idx == 3) begin
        base_addr = base + 5'd7;
        length    = 6'd5;
      end
      if (abort_after >= 0 && got == abort_after) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last",  32'(m_last),  32'd0);
        chk("rst_m_data",  32'(m_data),  32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("post_rst_done",  32'(done),    32'd0);
          chk("post_rst_valid", 32'(m_valid), 32'd0);
        end
        $display("burst base=%0d len=%0d aborted after %0d words", base, len, got);
        return;
      end
      m_ready = (stall_pct > 0) ? ($urandom_range(0, 99) >= stall_pct) : 1'b1;
      chk("done", 32'(done), 32'(done_due));
      chk("busy", 32'(busy), 32'(len != 0 && !finished));
      if (idx == 0 && len != 0) chk("rd_addr_base", 32'(rd_addr), 32'(base));
      if (stall_pct == 0) chk("valid_rate", 32'(m_valid), 32'(idx >= 2 && idx < 2 + len));
      if (stalled) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data",  32'(m_data),  32'(held));
      end
      xfer     = 1'b0;
      done_due = 1'b0;
      if (m_valid) begin
        if (expq.size() == 0) begin
          chk("extra_word", 32'(m_valid), 32'd0);
        end else begin
          chk("last", 32'(m_last), 32'(expq.size() == 1));
          if (m_ready) begin
            chk("data", 32'(m_data), 32'(expq[0]));
            void'(expq.pop_front());
            got++;
            xfer = 1'b1;
          end
        end
      end else begin
        chk("last_idle", 32'(m_last), 32'd0);
      end
      if (xfer && expq.size() == 0) begin
        done_due = 1'b1;
        finished = 1'b1;
        end_idx  = idx + 3;
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
      if (idx == end_idx) break;
    end
    chk("burst_words", 32'(got), 32'(len));
    m_ready = 1'b1;
    $display("burst base=%0d len=%0d words=%0d", base, len, got);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h10);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_last",  32'(m_last),  32'd0);
    chk("reset_m_data",  32'(m_data),  32'd0);
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_done",    32'(done),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst, full rate
    run_burst(5'd3, 4, 0, -1, 1'b0);
    // Address wrap at the top of the RAM
    run_burst(5'd30, 4, 0, -1, 1'b0);
    // Randomized data and backpressure
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    run_burst(AW'($urandom), 8, 50, -1, 1'b0);
    // Zero-length start
    run_burst(5'd9, 0, 0, -1, 1'b0);
    // Mid-burst reset after two words, then a clean rerun
    run_burst(5'd12, 6, 0, 2, 1'b0);
    run_burst(5'd12, 6, 0, -1, 1'b0);
    // Full-depth bursts with start re-asserted while busy
    run_burst(AW'($urandom), 32, 40, -1, 1'b1);
    run_burst(5'd5, 32, 0, -1, 1'b1);
    // Random mix
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      run_burst(AW'($urandom), int'($urandom_range(1, 32)), int'($urandom_range(0, 70)), -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
